// File: rtl/rr_compute_sched_pkg.sv
// Shared types and helpers for the round-robin compute scheduler.
// Imported by rr_arbiter and rr_compute_sched.
package rr_compute_sched_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    RESP
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin first-set search from a registered pointer.
// Pointer moves to winner+1 (mod N_REQ) when the grant is taken.
module rr_arbiter
  import rr_compute_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             take,
  output logic             gnt_valid,
  output logic [IW-1:0]    gnt_idx
);

  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    off;
  logic [IW:0]      sum;
  logic [IW:0]      nxt;

  // rotate so the pointer position lands at bit 0
  always_comb begin
    rot = N_REQ'({req, req} >> ptr_q);
    gnt_valid = 1'b0;
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_valid = 1'b1;
        off = IW'(k);
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (IW+1)'(N_REQ)) begin
      sum = sum - (IW+1)'(N_REQ);
    end
    gnt_idx = sum[IW-1:0];
    nxt = {1'b0, gnt_idx} + (IW+1)'(1);
    if (nxt >= (IW+1)'(N_REQ)) begin
      nxt = '0;
    end
    ptr_d = take ? nxt[IW-1:0] : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rr_compute_sched.sv
// Shares one start/done compute unit between N_REQ requesters.
// Optional abort on timeout: define RR_COMPUTE_SCHED_TIMEOUT_EN.
module rr_compute_sched
  import rr_compute_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic [N_REQ-1:0]       err,
  output logic                   u_start,
  output logic [WIDTH-1:0]       u_a,
  output logic [WIDTH-1:0]       u_b,
  input  logic [WIDTH-1:0]       u_result,
  input  logic                   u_done
);

  localparam int IW = idx_w(N_REQ);

  state_e           state_q;
  state_e           state_d;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;
  logic [WIDTH-1:0] ua_q;
  logic [WIDTH-1:0] ua_d;
  logic [WIDTH-1:0] ub_q;
  logic [WIDTH-1:0] ub_d;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] rd_d;

  logic             gnt_valid;
  logic [IW-1:0]    gnt_idx;
  logic             take;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [N_REQ-1:0] idx_oh;
  logic             abort;

  assign take   = (state_q == IDLE) && gnt_valid;
  assign idx_oh = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .take     (take),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        a_sel = a_in[i*WIDTH +: WIDTH];
        b_sel = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef RR_COMPUTE_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [N_REQ-1:0] err_q;
  logic [N_REQ-1:0] err_d;
  logic             in_wait;

  // a done arriving on the last allowed cycle still completes
  always_comb begin
    in_wait = (state_q == WAIT_LO) || (state_q == WAIT_HI);
    cnt_d   = in_wait ? cnt_q + CW'(1) : '0;
    abort   = in_wait
            && (cnt_q == CW'(TIMEOUT - 1))
            && !(state_q == WAIT_HI && u_done == 1'b1);
    err_d   = abort ? idx_oh : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign abort = 1'b0;
  // always zero; TIMEOUT is inert without the abort path
  assign err = {N_REQ{TIMEOUT < 0}};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT_LO;
      WAIT_LO: if (u_done == 1'b0) state_d = WAIT_HI;
      WAIT_HI: if (u_done == 1'b1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    idx_d = idx_q;
    ua_d  = ua_q;
    ub_d  = ub_q;
    rd_d  = rd_q;
    if (take) begin
      idx_d = gnt_idx;
      ua_d  = a_sel;
      ub_d  = b_sel;
    end
    if (state_q == WAIT_HI && u_done == 1'b1) begin
      rd_d = u_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ua_q    <= '0;
      ub_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    u_start    = 1'b0;
    ack        = '0;
    resp_valid = '0;
    unique case (state_q)
      ISSUE: begin
        u_start = 1'b1;
        ack     = idx_oh;
      end
      RESP:    resp_valid = idx_oh;
      default: ;
    endcase
  end

  assign u_a       = ua_q;
  assign u_b       = ub_q;
  assign resp_data = rd_q;

endmodule

// File: tb/tb_rr_compute_sched.sv
// Scoreboard bench for rr_compute_sched with a parent-level unit model.
// Unit computes (a+b)^2; its stale-done window and hang are tunable.
module tb_rr_compute_sched;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  typedef struct {
    int         idx;
    longint     cyc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_v = '0;
  logic [W-1:0]   a_v [N];
  logic [W-1:0]   b_v [N];
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   ack;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   err;
  logic [W-1:0]   resp_data;
  logic           u_start;
  logic [W-1:0]   u_a;
  logic [W-1:0]   u_b;
  logic [W-1:0]   u_result;
  logic           u_done;

  int     n_tests = 0;
  int     n_fail = 0;
  longint cyc = 0;
  int     d_stale = 0;
  bit     hang = 1'b0;
  int     t_u = 0;
  bit     act_u = 1'b0;
  int     ptr_m = 0;
  longint next_free = 0;

  exp_t ack_q[$];
  exp_t resp_q[$];
  exp_t err_q[$];
  int           log_idx[$];
  longint       log_cyc[$];
  logic [W-1:0] log_dat[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = a_v[i];
      b_in[i*W +: W] = b_v[i];
    end
  end

  rr_compute_sched #(
    .N_REQ(N), .WIDTH(W), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req_v),
    .a_in(a_in), .b_in(b_in), .ack(ack),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .err(err), .u_start(u_start), .u_a(u_a),
    .u_b(u_b), .u_result(u_result), .u_done(u_done)
  );

  function automatic logic [W-1:0] sq(input logic [W-1:0] a,
                                      input logic [W-1:0] b);
    logic [W-1:0] s;
    s = a + b;
    return s * s;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // compute unit: done sticky, falls d_stale cycles late, rises 2 later
  always @(posedge clk) begin
    if (reset) begin
      u_done <= 1'b0; act_u <= 1'b0; t_u <= 0; u_result <= '0;
    end else if (u_start) begin
      act_u <= 1'b1; t_u <= 1;
      if (d_stale == 0) u_done <= 1'b0;
    end else if (act_u) begin
      t_u <= t_u + 1;
      if (t_u == d_stale) u_done <= 1'b0;
      if (t_u == d_stale + 2 && !hang) begin
        u_done <= 1'b1;
        u_result <= sq(u_a, u_b);
        act_u <= 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, expv, cyc);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a pulse
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (ack !== '0) begin
        if (ack_q.size() == 0) check("ack_unexpected", ack, 0);
        else begin
          e = ack_q.pop_front();
          check("ack_onehot", ack, oh(e.idx));
          check("ack_cycle", cyc, e.cyc);
          check("u_start", u_start, 1);
          check("u_a", u_a, e.a);
          check("u_b", u_b, e.b);
        end
      end else if (ack_q.size() != 0 && ack_q[0].cyc <= cyc) begin
        e = ack_q.pop_front();
        check("ack_missing", ack, oh(e.idx));
      end
      if (resp_valid !== '0) begin
        log_idx.push_back(resp_valid[0] ? 0 : resp_valid[1] ? 1 :
                          resp_valid[2] ? 2 : 3);
        log_cyc.push_back(cyc);
        log_dat.push_back(resp_data);
        if (resp_q.size() == 0) check("resp_unexpected", resp_valid, 0);
        else begin
          e = resp_q.pop_front();
          check("resp_onehot", resp_valid, oh(e.idx));
          check("resp_cycle", cyc, e.cyc);
          check("resp_data", resp_data, e.data);
        end
      end else if (resp_q.size() != 0 && resp_q[0].cyc <= cyc) begin
        e = resp_q.pop_front();
        check("resp_missing", resp_valid, oh(e.idx));
      end
      if (err !== '0) begin
        if (err_q.size() == 0) check("err_unexpected", err, 0);
        else begin
          e = err_q.pop_front();
          check("err_onehot", err, oh(e.idx));
          check("err_cycle", cyc, e.cyc);
        end
      end else if (err_q.size() != 0 && err_q[0].cyc <= cyc) begin
        e = err_q.pop_front();
        check("err_missing", err, oh(e.idx));
      end
    end
  end

  // reference: one grant per free slot, first pending at/after pointer
  task automatic model_step();
    int   idx;
    exp_t e;
    if (cyc >= next_free && req_v != '0) begin
      idx = -1;
      for (int k = 0; k < N; k++) begin
        if (idx < 0 && req_v[(ptr_m + k) % N]) idx = (ptr_m + k) % N;
      end
      e.idx = idx; e.a = a_v[idx]; e.b = b_v[idx];
      e.data = sq(a_v[idx], b_v[idx]);
      e.cyc = cyc + 1;
      ack_q.push_back(e);
      ptr_m = (idx + 1) % N;
      if (hang) begin
`ifdef RR_COMPUTE_SCHED_TIMEOUT_EN
        e.cyc = cyc + 2 + TO;
        err_q.push_back(e);
        next_free = cyc + 2 + TO;
`else
        next_free = cyc + 1000000;
`endif
      end else begin
        e.cyc = cyc + 5 + d_stale;
        resp_q.push_back(e);
        next_free = cyc + 6 + d_stale;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_v[i] && ack[i]) req_v[i] = 1'b0;
    end
  endtask

  task automatic raise(input int i, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    req_v[i] = 1'b1; a_v[i] = a; b_v[i] = b;
  endtask

  task automatic run_rand(input int n, input int pct);
    for (int c = 0; c < n; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && $urandom_range(99) < pct)
          raise(i, $urandom, $urandom);
      end
      model_step();
    end
  endtask

  task automatic drain();
    bit done_f;
    done_f = 1'b0;
    for (int k = 0; k < 400 && !done_f; k++) begin
      if (ack_q.size() == 0 && resp_q.size() == 0 && err_q.size() == 0
          && cyc >= next_free && req_v == '0) done_f = 1'b1;
      else begin
        tick();
        model_step();
      end
    end
    check("drain_pending", ack_q.size() + resp_q.size() + err_q.size(), 0);
  endtask

  task automatic wait_ack(input int i);
    for (int k = 0; k < 40 && req_v[i]; k++) begin
      tick();
      model_step();
    end
    check("ack_wait", req_v[i], 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_v = '0;
    tick();
    reset = 1'b0;
    ack_q.delete(); resp_q.delete(); err_q.delete();
    ptr_m = 0;
    next_free = cyc;
    check("rst_ack", ack, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_err", err, 0);
    check("rst_u_start", u_start, 0);
    check("rst_u_a", u_a, 0);
    check("rst_u_b", u_b, 0);
    check("rst_resp_data", resp_data, 0);
  endtask

  initial begin
    longint g;
    int     n0;
    logic [W-1:0] ed [4];
    ed = '{32'd4, 32'd25, 32'd25, 32'd49};
    for (int i = 0; i < N; i++) begin a_v[i] = '0; b_v[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // single requester latency
    n0 = log_idx.size();
    raise(0, 3, 4); model_step(); g = cyc;
    drain();
    check("t1_count", log_idx.size() - n0, 1);
    check("t1_idx", log_idx[$], 0);
    check("t1_cycle", log_cyc[$], g + 5);
    check("t1_data", log_dat[$], 49);

    // four simultaneous requesters from reset
    do_reset();
    n0 = log_idx.size();
    raise(0, 1, 1); raise(1, 2, 3); raise(2, 0, 5); raise(3, 7, 0);
    model_step(); g = cyc;
    drain();
    check("t2_count", log_idx.size() - n0, 4);
    if (log_idx.size() - n0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t2_idx", log_idx[n0+k], k);
        check("t2_data", log_dat[n0+k], ed[k]);
        check("t2_cycle", log_cyc[n0+k], g + 5 + 6*k);
      end
    end

    // pointer after back-to-back grants to requester 2
    n0 = log_idx.size();
    raise(2, $urandom, $urandom); model_step();
    wait_ack(2);
    raise(2, $urandom, $urandom); model_step();
    wait_ack(2);
    raise(0, $urandom, $urandom); raise(2, $urandom, $urandom);
    model_step();
    drain();
    check("t3_count", log_idx.size() - n0, 4);
    if (log_idx.size() - n0 == 4) begin
      check("t3_first", log_idx[n0+2], 0);
      check("t3_second", log_idx[n0+3], 2);
    end

    // reset while in WAIT_HI abandons the operation
    n0 = log_idx.size();
    raise(0, 5, 6); model_step();
    for (int k = 0; k < 3; k++) begin tick(); model_step(); end
    do_reset();
    raise(3, 3, 4); model_step(); g = cyc;
    drain();
    check("t4_count", log_idx.size() - n0, 1);
    check("t4_idx", log_idx[$], 3);
    check("t4_cycle", log_cyc[$], g + 5);
    check("t4_data", log_dat[$], 49);

    // stale done held high across WAIT_LO
    d_stale = 3;
    raise(1, 2, 2); model_step(); g = cyc;
    drain();
    check("t5_cycle", log_cyc[$], g + 8);
    check("t5_data", log_dat[$], 16);

    for (int d = 0; d < 4; d++) begin
      d_stale = d;
      run_rand(200, 25);
      drain();
    end

    // unit never completes
    d_stale = 0;
    hang = 1'b1;
    raise(1, 9, 9); model_step();
    for (int k = 0; k < 45; k++) begin
      tick();
      if (k == 4) raise(3, 1, 2);
      model_step();
    end
`ifdef RR_COMPUTE_SCHED_TIMEOUT_EN
    check("t6_err_left", err_q.size(), 0);
    check("t6_ack_left", ack_q.size(), 0);
`else
    check("t6_still_waiting", req_v[3], 1);
    check("t6_err_idle", err, 0);
`endif
    hang = 1'b0;
    do_reset();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rr_compute_sched.md
Name: rr_compute_sched

Overview:
- Round-robin scheduler that shares one start/done compute unit (operands a, b; result; done) between N_REQ requesters.
- Captures the winning requester's operands and drives the unit's start pulse.
- Tracks the unit's done handshake, then returns the result to the winner as a one-cycle response.
- Sits between the requester clients and a single compute-unit instance. The unit is instantiated at the parent level, not inside this block.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 32, operand/result width
TIMEOUT, 16, max cycles in WAIT_LO+WAIT_HI before abort (used only with feature)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req  input  N_REQ  per-requester request level; held until ack
a_in  input  N_REQ*WIDTH  operand a, slice i belongs to requester i
b_in  input  N_REQ*WIDTH  operand b, slice i belongs to requester i
ack  output  N_REQ  one-hot pulse: operands captured, requester may drop req
resp_valid  output  N_REQ  one-hot pulse: resp_data valid for that requester
resp_data  output  WIDTH  result for the requester flagged by resp_valid
err  output  N_REQ  one-hot pulse: operation aborted by timeout (0 without feature)
u_start  output  1  start to compute unit
u_a  output  WIDTH  operand a to unit
u_b  output  WIDTH  operand b to unit
u_result  input  WIDTH  unit result
u_done  input  1  unit done level; sticky high after completion, cleared by unit one cycle after start is accepted

Behaviour:
- Interface decision: one clock clk; reset is synchronous, active-high, named reset.
- Reset values: state=IDLE, rr pointer=0, grant index=0, ack/resp_valid/err=0, u_start=0, u_a/u_b/resp_data=0. Reset mid-operation abandons the operation with no response; the compute unit is reset by the same signal.
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP.
- IDLE:
  - If any req is high, pick the first requester at or after the pointer (wrapping modulo N_REQ).
  - Latch its a_in/b_in slices into u_a/u_b and latch its index; go to ISSUE.
  - Pointer becomes index+1 mod N_REQ.
- ISSUE (1 cycle): u_start=1 and ack[idx]=1; go to WAIT_LO.
- WAIT_LO: u_start=0; wait until u_done==0, then go to WAIT_HI. This ignores a stale done from the previous operation; X on u_done counts as not 0.
- WAIT_HI: when u_done==1, capture u_result into resp_data and go to RESP.
- RESP (1 cycle): resp_valid[idx]=1; go to IDLE.
- u_a/u_b are held stable from IDLE capture through RESP and never change while the unit is busy.
- Latency with the standard unit: req seen in cycle 0 -> ack in cycle 1 -> resp_valid in cycle 5. Throughput: one operation per 6 cycles.
- Requests arriving while busy wait; req changes outside IDLE are ignored.
- Simultaneous requests are granted in pointer order, so each of N active requesters is served once per N grants.
- resp_data holds its value after RESP until the next capture.

Optional Feature:
- Macro: RR_COMPUTE_SCHED_TIMEOUT_EN.
- Enabled: a counter runs in WAIT_LO and WAIT_HI. On reaching TIMEOUT cycles:
  - err[idx] pulses for 1 cycle;
  - resp_valid stays 0 and resp_data is unchanged;
  - state returns to IDLE.
- Disabled: no counter; err is tied to 0; WAIT states wait indefinitely.

Decomposition:
- Shared package: state enum (IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP), default WIDTH constant, index-width helper function (clog2 of N_REQ).
- One natural sub-module, rr_arbiter: combinational first-set search from the pointer plus the registered pointer update, parameterised by N_REQ.

Test Plan:
- Single requester 0, a=3, b=4, paired with the standard unit -> ack[0] at cycle 1, resp_valid[0] at cycle 5, resp_data=49.
- Requesters 0..3 all high from reset, operands (1,1),(2,3),(0,5),(7,0) -> responses in order 0,1,2,3, data 4,25,25,49, 6 cycles apart.
- Requester 2 only, twice back-to-back, then requesters 0 and 2 together -> pointer at 3 after the second grant, so requester 0 wins first, then requester 2.
- Reset asserted in WAIT_HI, then released -> no resp_valid, all outputs 0; a new request completes with correct latency.
- Stale u_done=1 held from previous op with unit stalled in WAIT_LO -> no capture until done falls then rises.
- With RR_COMPUTE_SCHED_TIMEOUT_EN, TIMEOUT=16, unit model that never raises done -> err[idx] pulses 16 cycles after entering WAIT_LO; without the macro -> scheduler stays in WAIT_HI and err stays 0.
